pipeline_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). It owns the PC and per-stage valid bits, and keeps shadow copies of rd/reg_write/mem_read for EX, MEM and WB. From these it generates registered forwarding selects, load-use stalls, branch flushes and a data-memory wait freeze. It drives the enable/clear of the four pipeline registers and replaces the free-running PC logic and standalone forwarding unit.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 38 +++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 41 ++++
 rtl/pipeline_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard/sequencing controller.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN,
        STALL,
        FLUSH,
        FREEZE
    } pipe_evt_t;

    localparam int PC_STEP = 4;

    // vld_pipe bit positions: ID is the youngest stage, WB the oldest
    localparam int STAGES = 3;
    localparam int V_ID   = 0;
    localparam int V_EX   = 1;
    localparam int V_MEM  = 2;
    localparam int V_WB   = 3;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } ex_shadow_t;

    // mem_read is only needed while the load sits in EX, so later stages drop it
    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
    } fwd_src_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational load-use / RAW stall detection and next forward-select computation.
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic            valid_ex,
    input  logic            valid_mem,
    input  logic            valid_wb,
    input  ex_shadow_t      sh_ex,
    input  fwd_src_t        sh_mem,
    input  fwd_src_t        sh_wb,
    input  logic [1:0][4:0] rs_id,
    input  logic [1:0]      use_id,
    output logic            stall,
    output logic [1:0][1:0] fwd_nxt
);

    logic [1:0] ld_use;
    logic [1:0] raw;

    for (genvar g = 0; g < 2; g++) begin : g_src
        logic hit_ex, hit_mem, hit_wb;

        // x0 is excluded here so it can never stall or forward
        assign hit_ex  = valid_ex  & use_id[g] & (sh_ex.rd  != 5'd0) & (sh_ex.rd  == rs_id[g]);
        assign hit_mem = valid_mem & use_id[g] & (sh_mem.rd != 5'd0) & (sh_mem.rd == rs_id[g]);
        assign hit_wb  = valid_wb  & use_id[g] & (sh_wb.rd  != 5'd0) & (sh_wb.rd  == rs_id[g]);

        assign ld_use[g] = hit_ex & sh_ex.mem_read;
        assign raw[g]    = (hit_ex & sh_ex.reg_write) | (hit_mem & sh_mem.reg_write) |
                           (hit_wb & sh_wb.reg_write);

        assign fwd_nxt[g] = (FWD_EN == 0)                 ? FWD_REG :
                            (hit_ex  & sh_ex.reg_write)   ? FWD_MEM :
                            (hit_mem & sh_mem.reg_write)  ? FWD_WB  : FWD_REG;
    end

    assign stall = (|ld_use) | ((FWD_EN == 0) & (|raw));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: owns PC, stage valids and hazard shadows; drives register enables/clears.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int ADDR_SIZE = 10,
    parameter int FWD_EN    = 1,
    parameter int CNT_W     = 16
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 CLEAR,
    output logic [ADDR_SIZE-1:0] iaddr,
    output logic [ADDR_SIZE+1:0] pc_if,
    input  logic [4:0]           rs1_id,
    input  logic [4:0]           rs2_id,
    input  logic                 use_rs1_id,
    input  logic                 use_rs2_id,
    input  logic [4:0]           rd_id,
    input  logic                 reg_write_id,
    input  logic                 mem_read_id,
    input  logic                 branch_taken_mem,
    input  logic [ADDR_SIZE+1:0] branch_target_mem,
    input  logic                 dmem_access_mem,
    input  logic                 dmem_ready,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic                 if_id_clr,
    output logic                 id_ex_clr,
    output logic                 ex_mem_clr,
    output logic                 mem_wb_clr,
    output logic [1:0]           forwardA,
    output logic [1:0]           forwardB,
    output logic                 valid_wb,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    localparam int PC_W = ADDR_SIZE + 2;

    logic [PC_W-1:0]  pc_q;
    logic [STAGES:0]  vld_pipe;
    ex_shadow_t       sh_id, sh_ex;
    fwd_src_t         sh_mem, sh_wb;
    logic [1:0][1:0]  fwd_q, fwd_nxt;
    logic             dmem_wait, redirect, hz_stall;
    pipe_evt_t        evt;

    hazard_detect #(.FWD_EN(FWD_EN)) u_hazard_detect (
        .valid_ex  (vld_pipe[V_EX]),
        .valid_mem (vld_pipe[V_MEM]),
        .valid_wb  (vld_pipe[V_WB]),
        .sh_ex     (sh_ex),
        .sh_mem    (sh_mem),
        .sh_wb     (sh_wb),
        .rs_id     ({rs2_id, rs1_id}),
        .use_id    ({use_rs2_id, use_rs1_id}),
        .stall     (hz_stall),
        .fwd_nxt   (fwd_nxt)
    );

    assign dmem_wait = dmem_access_mem & vld_pipe[V_MEM] & ~dmem_ready;
    assign redirect  = branch_taken_mem & vld_pipe[V_MEM];

    // A branch seen during a memory wait stays in MEM and redirects once the wait ends
    always_comb begin
        evt = RUN;
        if (dmem_wait)     evt = FREEZE;
        else if (redirect) evt = FLUSH;
        else if (hz_stall) evt = STALL;
    end

    always_comb begin
        sh_id = '0;
        if (vld_pipe[V_ID]) sh_id = '{rd: rd_id, reg_write: reg_write_id, mem_read: mem_read_id};
    end

    always_comb begin
        {if_id_en, id_ex_en, ex_mem_en, mem_wb_en}     = 4'b1111;
        {if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr} = 4'b0000;
        if (CLEAR) begin
            {if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr} = 4'b1111;
        end else begin
            case (evt)
                FREEZE:  {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 4'b0000;
                FLUSH:   {if_id_clr, id_ex_clr, ex_mem_clr} = 3'b111;
                STALL: begin
                    if_id_en  = 1'b0;
                    id_ex_clr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q      <= '0;
            vld_pipe  <= '0;
            sh_ex     <= '0;
            sh_mem    <= '0;
            sh_wb     <= '0;
            fwd_q     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (CLEAR) begin
            pc_q      <= '0;
            vld_pipe  <= '0;
            sh_ex     <= '0;
            sh_mem    <= '0;
            sh_wb     <= '0;
            fwd_q     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            unique case (evt)
                RUN: begin
                    pc_q     <= pc_q + PC_W'(PC_STEP);
                    vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
                    sh_ex    <= sh_id;
                    sh_mem   <= fwd_src_t'{sh_ex.rd, sh_ex.reg_write};
                    sh_wb    <= sh_mem;
                    fwd_q    <= fwd_nxt;
                end
                STALL: begin
                    vld_pipe <= {vld_pipe[V_MEM:V_EX], 1'b0, vld_pipe[V_ID]};
                    sh_ex    <= '0;
                    sh_mem   <= fwd_src_t'{sh_ex.rd, sh_ex.reg_write};
                    sh_wb    <= sh_mem;
                    fwd_q    <= '0;
                    if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
                end
                FLUSH: begin
                    pc_q     <= branch_target_mem;
                    vld_pipe <= {vld_pipe[V_MEM], 3'b000};
                    sh_ex    <= '0;
                    sh_mem   <= '0;
                    sh_wb    <= sh_mem;
                    fwd_q    <= '0;
                    if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
                end
                FREEZE: ;
            endcase
        end
    end

    assign pc_if    = pc_q;
    assign iaddr    = pc_q[ADDR_SIZE+1:2];
    assign forwardA = fwd_q[0];
    assign forwardB = fwd_q[1];
    assign valid_wb = vld_pipe[V_WB];

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: forwarding, load-use, flush, freeze, FWD_EN=0, reset/clear.
module tb_pipeline_hazard_ctrl;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        CLEAR;
    logic [4:0]  rs1_id, rs2_id, rd_id;
    logic        use_rs1_id, use_rs2_id, reg_write_id, mem_read_id;
    logic        branch_taken_mem, dmem_access_mem, dmem_ready;
    logic [11:0] branch_target_mem;

    logic [9:0]  iaddr, z_iaddr;
    logic [11:0] pc_if, z_pc_if;
    logic        if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr;
    logic        z_if_id_en, z_id_ex_en, z_ex_mem_en, z_mem_wb_en;
    logic        z_if_id_clr, z_id_ex_clr, z_ex_mem_clr, z_mem_wb_clr;
    logic [1:0]  forwardA, forwardB, z_forwardA, z_forwardB;
    logic        valid_wb, z_valid_wb;
    logic [15:0] stall_cnt, flush_cnt;
    logic [2:0]  z_stall_cnt, z_flush_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.ADDR_SIZE(10), .FWD_EN(1), .CNT_W(16)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR), .iaddr(iaddr), .pc_if(pc_if),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
        .rd_id(rd_id), .reg_write_id(reg_write_id), .mem_read_id(mem_read_id),
        .branch_taken_mem(branch_taken_mem), .branch_target_mem(branch_target_mem),
        .dmem_access_mem(dmem_access_mem), .dmem_ready(dmem_ready),
        .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_clr(if_id_clr), .id_ex_clr(id_ex_clr), .ex_mem_clr(ex_mem_clr), .mem_wb_clr(mem_wb_clr),
        .forwardA(forwardA), .forwardB(forwardB), .valid_wb(valid_wb),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_hazard_ctrl #(.ADDR_SIZE(10), .FWD_EN(0), .CNT_W(3)) dut_nofwd (
        .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR), .iaddr(z_iaddr), .pc_if(z_pc_if),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
        .rd_id(rd_id), .reg_write_id(reg_write_id), .mem_read_id(mem_read_id),
        .branch_taken_mem(branch_taken_mem), .branch_target_mem(branch_target_mem),
        .dmem_access_mem(dmem_access_mem), .dmem_ready(dmem_ready),
        .if_id_en(z_if_id_en), .id_ex_en(z_id_ex_en), .ex_mem_en(z_ex_mem_en), .mem_wb_en(z_mem_wb_en),
        .if_id_clr(z_if_id_clr), .id_ex_clr(z_id_ex_clr), .ex_mem_clr(z_ex_mem_clr), .mem_wb_clr(z_mem_wb_clr),
        .forwardA(z_forwardA), .forwardB(z_forwardB), .valid_wb(z_valid_wb),
        .stall_cnt(z_stall_cnt), .flush_cnt(z_flush_cnt)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        CLEAR = 0; rs1_id = 0; rs2_id = 0; rd_id = 0;
        use_rs1_id = 0; use_rs2_id = 0; reg_write_id = 0; mem_read_id = 0;
        branch_taken_mem = 0; branch_target_mem = 0; dmem_access_mem = 0; dmem_ready = 1;
    endtask

    task automatic set_id(input logic [4:0] rd, input logic rw, input logic mr,
                          input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
        rd_id = rd; reg_write_id = rw; mem_read_id = mr;
        rs1_id = r1; use_rs1_id = u1; rs2_id = r2; use_rs2_id = u2;
    endtask

    // Leaves the bench mid-cycle with both DUTs freshly reset (cycle 0, PC=0)
    task automatic do_reset();
        tick();
        idle();
        RESET_N = 0;
        #2;
        RESET_N = 1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        #12 RESET_N = 1;
        repeat (3) tick();
        tick();
        RESET_N = 0;
        #2;
        n_chk++; if (iaddr !== 10'd0) begin n_fail++; $display("FAIL reset_iaddr got=%0d exp=0", iaddr); end
        n_chk++; if (pc_if !== 12'd0) begin n_fail++; $display("FAIL reset_pc got=%0h exp=0", pc_if); end
        n_chk++; if (valid_wb !== 1'b0) begin n_fail++; $display("FAIL reset_valid_wb got=%0b exp=0", valid_wb); end
        n_chk++; if ({forwardA, forwardB} !== 4'd0) begin n_fail++; $display("FAIL reset_fwd got=%0h exp=0", {forwardA, forwardB}); end
        n_chk++; if ({stall_cnt, flush_cnt} !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got=%0h exp=0", {stall_cnt, flush_cnt}); end
        n_chk++; if ({if_id_en, id_ex_en, ex_mem_en, mem_wb_en} !== 4'b1111) begin n_fail++; $display("FAIL reset_en got=%b exp=1111", {if_id_en, id_ex_en, ex_mem_en, mem_wb_en}); end
        n_chk++; if ({if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr} !== 4'b0000) begin n_fail++; $display("FAIL reset_clr got=%b exp=0000", {if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr}); end
        RESET_N = 1;
        #1;
    endtask

    task automatic test_run();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            n_chk++; if (iaddr !== 10'(k)) begin n_fail++; $display("FAIL run_iaddr c%0d got=%0d exp=%0d", k, iaddr, k); end
            n_chk++; if (valid_wb !== (k >= 4)) begin n_fail++; $display("FAIL run_valid_wb c%0d got=%0b exp=%0b", k, valid_wb, (k >= 4)); end
            tick();
        end
        n_chk++; if ({stall_cnt, flush_cnt} !== 32'd0) begin n_fail++; $display("FAIL run_cnt got=%0h exp=0", {stall_cnt, flush_cnt}); end
    endtask

    task automatic test_forward();
        // producer immediately ahead of consumer: select MEM ALU result
        do_reset(); tick();
        set_id(5, 1, 0, 1, 1, 2, 1); tick();
        set_id(6, 1, 0, 5, 1, 1, 1); #1;
        n_chk++; if (if_id_en !== 1'b1) begin n_fail++; $display("FAIL fwd_gap0_nostall got=%0b exp=1", if_id_en); end
        tick();
        n_chk++; if (forwardA !== 2'd2) begin n_fail++; $display("FAIL fwd_gap0_A got=%0d exp=2", forwardA); end
        n_chk++; if (forwardB !== 2'd0) begin n_fail++; $display("FAIL fwd_gap0_B got=%0d exp=0", forwardB); end
        // one unrelated instruction in between: select WB result
        do_reset(); tick();
        set_id(5, 1, 0, 1, 1, 2, 1); tick();
        set_id(7, 1, 0, 3, 1, 4, 1); tick();
        set_id(6, 1, 0, 5, 1, 1, 1); tick();
        n_chk++; if (forwardA !== 2'd1) begin n_fail++; $display("FAIL fwd_gap1_A got=%0d exp=1", forwardA); end
        // x0 destination never forwards
        do_reset(); tick();
        set_id(0, 1, 0, 1, 1, 2, 1); tick();
        set_id(6, 1, 0, 0, 1, 0, 1); tick();
        n_chk++; if ({forwardA, forwardB} !== 4'd0) begin n_fail++; $display("FAIL fwd_x0 got=%0h exp=0", {forwardA, forwardB}); end
        // two writers of x5 in flight: the younger (select 2) wins
        do_reset(); tick();
        set_id(5, 1, 0, 1, 1, 2, 1); tick();
        set_id(5, 1, 0, 1, 1, 0, 0); tick();
        set_id(6, 1, 0, 5, 1, 5, 1); tick();
        n_chk++; if ({forwardA, forwardB} !== 4'b1010) begin n_fail++; $display("FAIL fwd_prio got=%0h exp=a", {forwardA, forwardB}); end
        idle();
    endtask

    task automatic test_load_use();
        do_reset(); tick();
        set_id(5, 1, 1, 2, 1, 0, 0); tick();
        set_id(6, 1, 0, 5, 1, 5, 1); #1;
        n_chk++; if ({if_id_en, id_ex_clr} !== 2'b01) begin n_fail++; $display("FAIL lu_stall got=%b exp=01", {if_id_en, id_ex_clr}); end
        tick();
        n_chk++; if ({if_id_en, id_ex_clr} !== 2'b10) begin n_fail++; $display("FAIL lu_release got=%b exp=10", {if_id_en, id_ex_clr}); end
        n_chk++; if (iaddr !== 10'd2) begin n_fail++; $display("FAIL lu_pc_hold got=%0d exp=2", iaddr); end
        tick();
        n_chk++; if ({forwardA, forwardB} !== 4'b0101) begin n_fail++; $display("FAIL lu_fwd got=%0h exp=5", {forwardA, forwardB}); end
        n_chk++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
        n_chk++; if (iaddr !== 10'd3) begin n_fail++; $display("FAIL lu_pc_resume got=%0d exp=3", iaddr); end
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        repeat (3) tick();
        branch_taken_mem = 1; branch_target_mem = 12'h040; #1;
        n_chk++; if ({if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr} !== 4'b1110) begin n_fail++; $display("FAIL fl_clr got=%b exp=1110", {if_id_clr, id_ex_clr, ex_mem_clr, mem_wb_clr}); end
        tick();
        branch_taken_mem = 0;
        n_chk++; if (iaddr !== 10'h010) begin n_fail++; $display("FAIL fl_iaddr got=%0h exp=10", iaddr); end
        n_chk++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL fl_cnt got=%0d exp=1", flush_cnt); end
        n_chk++; if (valid_wb !== 1'b1) begin n_fail++; $display("FAIL fl_wb_proceeds got=%0b exp=1", valid_wb); end
        for (int c = 5; c <= 8; c++) begin
            tick();
            n_chk++; if (valid_wb !== (c == 8)) begin n_fail++; $display("FAIL fl_valid_wb c%0d got=%0b exp=%0b", c, valid_wb, (c == 8)); end
        end
    endtask

    task automatic test_freeze();
        do_reset();
        repeat (3) tick();
        dmem_access_mem = 1; dmem_ready = 0;
        branch_taken_mem = 1; branch_target_mem = 12'h080;
        for (int j = 0; j < 3; j++) begin
            #1;
            n_chk++; if ({if_id_en, id_ex_en, ex_mem_en, mem_wb_en} !== 4'b0000) begin n_fail++; $display("FAIL fz_en w%0d got=%b exp=0000", j, {if_id_en, id_ex_en, ex_mem_en, mem_wb_en}); end
            n_chk++; if (iaddr !== 10'd3) begin n_fail++; $display("FAIL fz_pc w%0d got=%0d exp=3", j, iaddr); end
            tick();
        end
        dmem_ready = 1; #1;
        n_chk++; if ({if_id_clr, ex_mem_clr, mem_wb_en, flush_cnt} !== {3'b111, 16'd0}) begin n_fail++; $display("FAIL fz_release got=%0h exp=%0h", {if_id_clr, ex_mem_clr, mem_wb_en, flush_cnt}, {3'b111, 16'd0}); end
        tick();
        idle();
        n_chk++; if (iaddr !== 10'h020) begin n_fail++; $display("FAIL fz_redirect got=%0h exp=20", iaddr); end
        n_chk++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL fz_flush_cnt got=%0d exp=1", flush_cnt); end
    endtask

    task automatic test_fwd_off();
        do_reset(); tick();
        set_id(5, 1, 0, 1, 1, 3, 1); tick();
        set_id(7, 1, 0, 5, 1, 2, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_chk++; if (z_if_id_en !== (i == 3)) begin n_fail++; $display("FAIL nf_if_id_en c%0d got=%0b exp=%0b", i + 2, z_if_id_en, (i == 3)); end
            tick();
        end
        n_chk++; if (z_forwardA !== 2'd0) begin n_fail++; $display("FAIL nf_fwdA got=%0d exp=0", z_forwardA); end
        n_chk++; if (z_stall_cnt !== 3'd3) begin n_fail++; $display("FAIL nf_stall_cnt got=%0d exp=3", z_stall_cnt); end
        idle();
    endtask

    task automatic test_saturate();
        do_reset(); tick();
        for (int it = 0; it < 3; it++) begin
            set_id(5, 1, 0, 0, 0, 0, 0); tick();
            set_id(7, 1, 0, 5, 1, 0, 0);
            repeat (4) tick();
            if (it == 1) begin
                n_chk++; if (z_stall_cnt !== 3'd6) begin n_fail++; $display("FAIL sat_pre got=%0d exp=6", z_stall_cnt); end
            end
        end
        n_chk++; if (z_stall_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_hold got=%0d exp=7", z_stall_cnt); end
        idle();
    endtask

    task automatic test_reset_mid_stall();
        do_reset(); tick();
        set_id(5, 1, 0, 1, 1, 3, 1); tick();
        set_id(7, 1, 0, 5, 1, 2, 1); tick(); tick();
        n_chk++; if ({z_iaddr, z_valid_wb, z_stall_cnt} !== {10'd2, 1'b1, 3'd2}) begin n_fail++; $display("FAIL rst_pre got=%0h exp=%0h", {z_iaddr, z_valid_wb, z_stall_cnt}, {10'd2, 1'b1, 3'd2}); end
        RESET_N = 0; #1;
        n_chk++; if ({z_iaddr, z_valid_wb, z_stall_cnt, z_if_id_en} !== {10'd0, 1'b0, 3'd0, 1'b1}) begin n_fail++; $display("FAIL rst_async got=%0h exp=%0h", {z_iaddr, z_valid_wb, z_stall_cnt, z_if_id_en}, {10'd0, 1'b0, 3'd0, 1'b1}); end
        RESET_N = 1;
        do_reset(); tick();
        set_id(5, 1, 0, 1, 1, 3, 1); tick();
        set_id(7, 1, 0, 5, 1, 2, 1); tick(); tick();
        CLEAR = 1; #1;
        n_chk++; if (z_iaddr !== 10'd2) begin n_fail++; $display("FAIL clr_sync_wait got=%0d exp=2", z_iaddr); end
        tick();
        CLEAR = 0;
        n_chk++; if ({z_iaddr, z_valid_wb, z_stall_cnt} !== {10'd0, 1'b0, 3'd0}) begin n_fail++; $display("FAIL clr_state got=%0h exp=0", {z_iaddr, z_valid_wb, z_stall_cnt}); end
        idle();
    endtask

    task automatic test_pc_wrap();
        do_reset();
        repeat (1023) tick();
        n_chk++; if ({iaddr, pc_if} !== {10'd1023, 12'hFFC}) begin n_fail++; $display("FAIL wrap_top got=%0h exp=%0h", {iaddr, pc_if}, {10'd1023, 12'hFFC}); end
        tick();
        n_chk++; if (pc_if !== 12'd0) begin n_fail++; $display("FAIL wrap_zero got=%0h exp=0", pc_if); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_forward();
        test_load_use();
        test_flush();
        test_freeze();
        test_fwd_off();
        test_saturate();
        test_reset_mid_stall();
        test_pc_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
